// File: rtl/load_store_unit_if.sv
// Execute-stage request, data-memory bus and writeback/fault signals of the LSU.
// The slave modport is the LSU's view; master is the surrounding core/memory.
interface load_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [4:0]  rdIn;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemBe;
  logic        dmemAck;
  logic [31:0] dmemRdata;
  logic        wbValid;
  logic        wbWe;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        fault;
  logic [1:0]  faultCause;
  logic [31:0] faultAddr;

  modport slave (
    input  reqValid, memRead, memWrite, funct3, address, storeData, rdIn,
    input  dmemAck, dmemRdata,
    output reqReady, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output wbValid, wbWe, wbRd, wbData, fault, faultCause, faultAddr
  );

  modport master (
    output reqValid, memRead, memWrite, funct3, address, storeData, rdIn,
    output dmemAck, dmemRdata,
    input  reqReady, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  wbValid, wbWe, wbRd, wbData, fault, faultCause, faultAddr
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 memory stage: one load or store per request on the data bus, with
// byte-lane formatting, load extension and misaligned/illegal/timeout faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave lsu
);
  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE, FAULT} state_t;
  state_t state, state_n;

  logic [CW-1:0] tcnt;
  logic [31:0]   addr_q;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic          load_q;

  logic          is_op, illegal, misaligned, accept, timeout;
  logic [1:0]    cause_n;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n, lane, ld_fmt;

  assign lsu.reqReady = (state == IDLE);

  // Request decode and store formatting, evaluated on the incoming request.
  always_comb begin
    is_op      = lsu.memRead | lsu.memWrite;
    illegal    = (lsu.funct3 == 3'b011) || (lsu.funct3[2:1] == 2'b11) ||
                 (!lsu.memRead && lsu.funct3[2]);
    misaligned = ((lsu.funct3[1:0] == 2'b01) && lsu.address[0]) ||
                 ((lsu.funct3 == 3'b010) && (lsu.address[1:0] != 2'b00));
    cause_n    = illegal ? 2'b10 : 2'b01;
    be_n       = 4'b1111;
    wdata_n    = '0;
    if (!lsu.memRead) begin
      case (lsu.funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << lsu.address[1:0];
          wdata_n = {4{lsu.storeData[7:0]}};
        end
        2'b01: begin
          be_n    = lsu.address[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{lsu.storeData[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = lsu.storeData;
        end
      endcase
    end
  end

  // Load alignment and extension from the latched funct3/offset.
  always_comb begin
    lane = lsu.dmemRdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_fmt = {24'd0, lane[7:0]};
      3'b101:  ld_fmt = {16'd0, lane[15:0]};
      default: ld_fmt = lane;
    endcase
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (lsu.reqValid) begin
          accept = 1'b1;
          if (is_op) state_n = (illegal || misaligned) ? FAULT : BUS;
        end
      end
      BUS: begin
        if (lsu.dmemAck) begin
          state_n = DONE;
        end else if (tcnt == LAST) begin
          timeout = 1'b1;
          state_n = FAULT;
        end
      end
      DONE:    state_n = IDLE;
      FAULT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tcnt           <= '0;
      addr_q         <= '0;
      f3_q           <= '0;
      rd_q           <= '0;
      load_q         <= 1'b0;
      lsu.dmemReq    <= 1'b0;
      lsu.dmemWe     <= 1'b0;
      lsu.dmemAddr   <= '0;
      lsu.dmemWdata  <= '0;
      lsu.dmemBe     <= '0;
      lsu.wbValid    <= 1'b0;
      lsu.wbWe       <= 1'b0;
      lsu.wbRd       <= '0;
      lsu.wbData     <= '0;
      lsu.fault      <= 1'b0;
      lsu.faultCause <= '0;
      lsu.faultAddr  <= '0;
    end else begin
      state       <= state_n;
      tcnt        <= (state == BUS) ? tcnt + CW'(1) : '0;
      lsu.dmemReq <= (state_n == BUS);
      lsu.wbValid <= (state_n == DONE);
      lsu.wbWe    <= (state_n == DONE) && load_q && (rd_q != 5'd0);
      lsu.fault   <= (state_n == FAULT);
      if (accept && is_op) begin
        addr_q <= lsu.address;
        f3_q   <= lsu.funct3;
        rd_q   <= lsu.rdIn;
        load_q <= lsu.memRead;
        if (illegal || misaligned) begin
          lsu.faultCause <= cause_n;
          lsu.faultAddr  <= lsu.address;
        end else begin
          lsu.dmemWe    <= !lsu.memRead;
          lsu.dmemAddr  <= {lsu.address[31:2], 2'b00};
          lsu.dmemWdata <= wdata_n;
          lsu.dmemBe    <= be_n;
        end
      end
      if (timeout) begin
        lsu.faultCause <= 2'b11;
        lsu.faultAddr  <= addr_q;
      end
      if (state == BUS && lsu.dmemAck) begin
        lsu.wbRd   <= rd_q;
        lsu.wbData <= load_q ? ld_fmt : '0;
      end
    end
  end
endmodule
